bcd_display_scanner: RTL and testbench

Multiplexed three-digit seven-segment driver that sits directly downstream of the two-digit BCD adder. It captures the adder's 8-bit BCD SUM and CARRY on a load strobe and time-multiplexes the hundreds, tens and ones digits onto a shared segment bus. It also provides leading-zero blanking and flags non-BCD input. All outputs are registered.

---
 rtl/bcd_display_scanner.sv | 112 +++++++++++
 tb/tb_bcd_display_scanner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Three-digit multiplexed seven-segment driver for a captured BCD sum and carry.
// Scans ones -> tens -> hundreds with optional leading-zero blanking and a non-BCD flag.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 1000,
  parameter int LZ_BLANK    = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LOAD,
  input  logic [7:0] SUM,
  input  logic       CARRY,
  output logic [6:0] SEG,
  output logic [2:0] AN,
  output logic       ERR
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] IDX_ONES = 2'd0;
  localparam logic [1:0] IDX_TENS = 2'd1;
  localparam logic [1:0] IDX_HUND = 2'd2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [8:0]    held_q, held_d;
  logic          err_q, err_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h40;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      idx_q  <= IDX_ONES;
      held_q <= '0;
      err_q  <= 1'b0;
      seg_q  <= 7'h3F;
      an_q   <= 3'b001;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      held_q <= held_d;
      err_q  <= err_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  // Scan cadence is free-running; LOAD only touches the held value and ERR.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    held_d = held_q;
    err_d  = err_q;
    if (cnt_q == TC) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_HUND) ? IDX_ONES : idx_q + 2'd1;
    end
    if (LOAD) begin
      held_d = {CARRY, SUM};
      err_d  = (SUM[7:4] > 4'd9) || (SUM[3:0] > 4'd9);
    end
  end

  // Outputs follow the registered index and held value, one cycle behind them.
  always_comb begin
    seg_d = seg_of(held_q[3:0]);
    an_d  = 3'b001;
    case (idx_q)
      IDX_TENS: begin
        if ((LZ_BLANK != 0) && !held_q[8] && (held_q[7:4] == 4'd0)) begin
          seg_d = 7'h00;
          an_d  = 3'b000;
        end else begin
          seg_d = seg_of(held_q[7:4]);
          an_d  = 3'b010;
        end
      end
      IDX_HUND: begin
        if ((LZ_BLANK != 0) && !held_q[8]) begin
          seg_d = 7'h00;
          an_d  = 3'b000;
        end else begin
          seg_d = held_q[8] ? 7'h06 : 7'h3F;
          an_d  = 3'b100;
        end
      end
      default: ;
    endcase
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: a blanking and a non-blanking instance share stimulus;
// a cycle model feeds an expected queue, and each scenario adds its own slot checks.
module tb_bcd_display_scanner;

  localparam int R = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       LOAD;
  logic [7:0] SUM;
  logic       CARRY;
  logic [6:0] seg_b, seg_n;
  logic [2:0] an_b, an_n;
  logic       err_b, err_n;

  int n_cmp = 0;
  int n_err = 0;

  bcd_display_scanner #(.REFRESH_DIV(R), .LZ_BLANK(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .SUM(SUM), .CARRY(CARRY),
    .SEG(seg_b), .AN(an_b), .ERR(err_b)
  );

  bcd_display_scanner #(.REFRESH_DIV(R), .LZ_BLANK(0)) dut_nb (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .SUM(SUM), .CARRY(CARRY),
    .SEG(seg_n), .AN(an_n), .ERR(err_n)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // model and expected queue: {err, seg, an} for the blanking then the non-blanking instance
  logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int          m_cnt = 0;
  logic [1:0]  m_idx = 2'd0;
  logic [8:0]  m_held = 9'd0;
  logic        m_err = 1'b0;
  logic [9:0]  m_ob, m_on;
  logic [21:0] exp_q[$];

  function automatic logic [6:0] model_seg(input logic [3:0] n);
    return (n > 4'd9) ? 7'h40 : seg_tab[n];
  endfunction

  function automatic logic [9:0] exp_out(input logic [1:0] idx, input logic [8:0] h, input bit lz);
    case (idx)
      2'd1: return (lz && !h[8] && h[7:4] == 4'd0) ? 10'd0 : {model_seg(h[7:4]), 3'b010};
      2'd2: return (lz && !h[8]) ? 10'd0 : {(h[8] ? 7'h06 : 7'h3F), 3'b100};
      default: return {model_seg(h[3:0]), 3'b001};
    endcase
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_cnt = 0; m_idx = 2'd0; m_held = 9'd0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      m_ob = exp_out(m_idx, m_held, 1'b1);
      m_on = exp_out(m_idx, m_held, 1'b0);
      if (LOAD) begin
        m_held = {CARRY, SUM};
        m_err  = (SUM[7:4] > 4'd9) || (SUM[3:0] > 4'd9);
      end
      if (m_cnt == R - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == 2'd2) ? 2'd0 : m_idx + 2'd1;
      end else begin
        m_cnt++;
      end
      exp_q.push_back({m_err, m_ob, m_err, m_on});
    end
  end

  function automatic logic [21:0] obs();
    return {err_b, seg_b, an_b, err_n, seg_n, an_n};
  endfunction

  // driver: advance one edge, sample 1ns later and dequeue the matching expectation
  task automatic step(output logic [21:0] e, output bit ok);
    @(posedge CLK); #1;
    ok = (exp_q.size() != 0);
    e  = '0;
    if (ok) e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    RST_N = 1'b0; LOAD = 1'b0; SUM = 8'h00; CARRY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({seg_b, an_b, err_b} !== {7'h3F, 3'b001, 1'b0}) begin
      n_err++; $display("FAIL reset_lz got %h/%b/%b want 3f/001/0", seg_b, an_b, err_b);
    end
    n_cmp++;
    if ({seg_n, an_n, err_n} !== {7'h3F, 3'b001, 1'b0}) begin
      n_err++; $display("FAIL reset_nb got %h/%b/%b want 3f/001/0", seg_n, an_n, err_n);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_value_83();
    logic [21:0] e; bit ok; int blanks = 0;
    LOAD = 1'b1; SUM = 8'h83; CARRY = 1'b0;
    step(e, ok); n_cmp++;
    if (!ok || obs() !== e) begin n_err++; $display("FAIL v83_load_sb got %h want %h", obs(), e); end
    n_cmp++;
    if (err_b !== 1'b0) begin n_err++; $display("FAIL v83_err got %b want 0", err_b); end
    LOAD = 1'b0;
    for (int i = 0; i < 3 * R; i++) begin
      step(e, ok); n_cmp++;
      if (!ok || obs() !== e) begin n_err++; $display("FAIL v83_sb cyc %0d got %h want %h", i, obs(), e); end
      n_cmp++;
      if (!((an_b == 3'b001 && seg_b == 7'h4F) || (an_b == 3'b010 && seg_b == 7'h7F) ||
            (an_b == 3'b000 && seg_b == 7'h00))) begin
        n_err++; $display("FAIL v83_slot cyc %0d got %h/%b", i, seg_b, an_b);
      end
      if (an_b == 3'b000) blanks++;
    end
    n_cmp++;
    if (blanks != R) begin n_err++; $display("FAIL v83_blank_cycles got %0d want %0d", blanks, R); end
  endtask

  task automatic test_value_198();
    logic [21:0] e; bit ok; logic [2:0] prev_an; int last_chg = -1;
    LOAD = 1'b1; SUM = 8'h98; CARRY = 1'b1;
    step(e, ok); n_cmp++;
    if (!ok || obs() !== e) begin n_err++; $display("FAIL v198_load_sb got %h want %h", obs(), e); end
    LOAD = 1'b0;
    for (int i = 0; i < 3 * R; i++) begin
      step(e, ok); n_cmp++;
      if (!ok || obs() !== e) begin n_err++; $display("FAIL v198_sb cyc %0d got %h want %h", i, obs(), e); end
      n_cmp++;
      if (!((an_b == 3'b001 && seg_b == 7'h7F) || (an_b == 3'b010 && seg_b == 7'h6F) ||
            (an_b == 3'b100 && seg_b == 7'h06))) begin
        n_err++; $display("FAIL v198_slot cyc %0d got %h/%b", i, seg_b, an_b);
      end
    end
    // LOAD held high across terminal counts: value and cadence unchanged
    LOAD = 1'b1;
    prev_an = an_b;
    for (int i = 0; i < 3 * R + 2; i++) begin
      step(e, ok); n_cmp++;
      if (!ok || obs() !== e) begin n_err++; $display("FAIL v198_hold_sb cyc %0d got %h want %h", i, obs(), e); end
      if (an_b !== prev_an) begin
        if (last_chg >= 0) begin
          n_cmp++;
          if (i - last_chg != R) begin
            n_err++; $display("FAIL v198_cadence slot got %0d want %0d", i - last_chg, R);
          end
        end
        last_chg = i;
      end
      prev_an = an_b;
    end
    LOAD = 1'b0;
  endtask

  task automatic test_blanking();
    logic [21:0] e; bit ok; int blanks = 0;
    LOAD = 1'b1; SUM = 8'h05; CARRY = 1'b0;
    step(e, ok); n_cmp++;
    if (!ok || obs() !== e) begin n_err++; $display("FAIL lz_load_sb got %h want %h", obs(), e); end
    LOAD = 1'b0;
    for (int i = 0; i < 3 * R; i++) begin
      step(e, ok); n_cmp++;
      if (!ok || obs() !== e) begin n_err++; $display("FAIL lz_sb cyc %0d got %h want %h", i, obs(), e); end
      n_cmp++;
      if (!((an_b == 3'b001 && seg_b == 7'h6D) || (an_b == 3'b000 && seg_b == 7'h00))) begin
        n_err++; $display("FAIL lz_slot cyc %0d got %h/%b", i, seg_b, an_b);
      end
      n_cmp++;
      if (!((an_n == 3'b001 && seg_n == 7'h6D) || (an_n == 3'b010 && seg_n == 7'h3F) ||
            (an_n == 3'b100 && seg_n == 7'h3F))) begin
        n_err++; $display("FAIL nolz_slot cyc %0d got %h/%b", i, seg_n, an_n);
      end
      if (an_b == 3'b000) blanks++;
    end
    n_cmp++;
    if (blanks != 2 * R) begin n_err++; $display("FAIL lz_blank_cycles got %0d want %0d", blanks, 2 * R); end
  endtask

  task automatic test_invalid();
    logic [21:0] e; bit ok;
    LOAD = 1'b1; SUM = 8'hA3; CARRY = 1'b0;
    step(e, ok); n_cmp++;
    if (!ok || obs() !== e) begin n_err++; $display("FAIL bad_load_sb got %h want %h", obs(), e); end
    n_cmp++;
    if (err_b !== 1'b1 || err_n !== 1'b1) begin n_err++; $display("FAIL bad_err got %b%b want 11", err_b, err_n); end
    LOAD = 1'b0;
    for (int i = 0; i < 3 * R; i++) begin
      step(e, ok); n_cmp++;
      if (!ok || obs() !== e) begin n_err++; $display("FAIL bad_sb cyc %0d got %h want %h", i, obs(), e); end
      n_cmp++;
      if (!((an_b == 3'b001 && seg_b == 7'h4F) || (an_b == 3'b010 && seg_b == 7'h40) ||
            (an_b == 3'b000 && seg_b == 7'h00))) begin
        n_err++; $display("FAIL bad_slot cyc %0d got %h/%b", i, seg_b, an_b);
      end
    end
    LOAD = 1'b1; SUM = 8'h12; CARRY = 1'b0;
    step(e, ok); n_cmp++;
    if (!ok || obs() !== e) begin n_err++; $display("FAIL clr_load_sb got %h want %h", obs(), e); end
    n_cmp++;
    if (err_b !== 1'b0) begin n_err++; $display("FAIL clr_err got %b want 0", err_b); end
    LOAD = 1'b0;
  endtask

  task automatic test_collision();
    logic [21:0] e; bit ok; bit found = 1'b0;
    for (int i = 0; i < 4 * R; i++) begin
      step(e, ok); n_cmp++;
      if (!ok || obs() !== e) begin n_err++; $display("FAIL col_wait_sb cyc %0d got %h want %h", i, obs(), e); end
      if (m_idx == 2'd0 && m_cnt == R - 1) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL col_align got timeout want ones terminal count"); end
    LOAD = 1'b1; SUM = 8'h45; CARRY = 1'b0;
    step(e, ok); n_cmp++;
    if (!ok || obs() !== e) begin n_err++; $display("FAIL col_load_sb got %h want %h", obs(), e); end
    LOAD = 1'b0;
    for (int i = 1; i <= R + 1; i++) begin
      step(e, ok); n_cmp++;
      if (!ok || obs() !== e) begin n_err++; $display("FAIL col_sb cyc %0d got %h want %h", i, obs(), e); end
      n_cmp++;
      if (i <= R && (an_b !== 3'b010 || seg_b !== 7'h66)) begin
        n_err++; $display("FAIL col_tens cyc %0d got %h/%b want 66/010", i, seg_b, an_b);
      end else if (i == R + 1 && an_b !== 3'b000) begin
        n_err++; $display("FAIL col_hund cyc %0d got %b want 000", i, an_b);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [21:0] e; bit ok;
    LOAD = 1'b1; SUM = 8'hA3; CARRY = 1'b1;
    step(e, ok);
    LOAD = 1'b0;
    for (int i = 0; i < R + 1; i++) begin
      step(e, ok); n_cmp++;
      if (!ok || obs() !== e) begin n_err++; $display("FAIL rst_pre_sb cyc %0d got %h want %h", i, obs(), e); end
    end
    #2 RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({seg_b, an_b, err_b} !== {7'h3F, 3'b001, 1'b0}) begin
      n_err++; $display("FAIL rst_async got %h/%b/%b want 3f/001/0", seg_b, an_b, err_b);
    end
    LOAD = 1'b1; SUM = 8'h99; CARRY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      n_cmp++;
      if ({seg_b, an_b, err_b, seg_n, an_n} !== {7'h3F, 3'b001, 1'b0, 7'h3F, 3'b001}) begin
        n_err++; $display("FAIL rst_hold cyc %0d got %h/%b/%b want 3f/001/0", i, seg_b, an_b, err_b);
      end
    end
    RST_N = 1'b1; LOAD = 1'b0;
    for (int i = 0; i < 3 * R; i++) begin
      step(e, ok); n_cmp++;
      if (!ok || obs() !== e) begin n_err++; $display("FAIL rst_post_sb cyc %0d got %h want %h", i, obs(), e); end
      n_cmp++;
      if (i < R && ({seg_b, an_b, err_b} !== {7'h3F, 3'b001, 1'b0})) begin
        n_err++; $display("FAIL rst_ones cyc %0d got %h/%b/%b want 3f/001/0", i, seg_b, an_b, err_b);
      end else if (i >= R && ({seg_b, an_b} !== {7'h00, 3'b000})) begin
        n_err++; $display("FAIL rst_blank cyc %0d got %h/%b want 00/000", i, seg_b, an_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_value_83();
    test_value_198();
    test_blanking();
    test_invalid();
    test_collision();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
